dosificador: RTL and testbench
==============================

# dosificador

Metering stage directly downstream of the paint-loading FSM. It consumes the one-hot `Motores` request (R = 3'b100, Y = 3'b010, B = 3'b001), drives the selected pump motor for the number of dose units stored for that colour, and returns the per-colour completion flags (`flag_R`, `flag_G`, `flag_B`) that advance the FSM. Dose values are loaded per colour from the keypad digit path before the load sequence starts.

## Interface
- `TICKS_PER_UNIT`, 5_000_000: clock cycles per dose unit (≥2).
- `DOSE_MAX`, 9: largest accepted dose value.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `Motores`  in  3  one-hot motor request from the FSM; 000 = none.
- `load_en`  in  1  one-cycle strobe: write `load_val` into dose register `load_sel`.
- `load_sel`  in  2  0 = R, 1 = Y, 2 = B, 3 = ignored.
- `load_val`  in  5  digit code; 0–`DOSE_MAX` valid; display codes 16 (blank) and 17 (dash), and every other value above `DOSE_MAX`, are rejected.
- `motor_out`  out  3  pump drive, same bit order as `Motores`.
- `flag_R`, `flag_G`, `flag_B`  out  1 each  one-cycle done pulse (R, Y, B channel respectively).
- `busy`  out  1  high in RUN and DONE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `motor_out` = 000. Start condition: `Motores` is a legal one-hot value and its set bit was 0 in the previous cycle (rising edge). On start, latch channel and `remaining` = dose[channel], clear prescaler, then:
  - if dose ≠ 0, go to RUN;
  - if dose = 0, go straight to DONE without driving the motor.
- RUN: `motor_out` = one-hot of the latched channel.
  - Prescaler counts 0..`TICKS_PER_UNIT`-1. On wrap, `remaining` decrements.
  - When it decrements from 1 to 0, go to DONE.
- DONE: `motor_out` = 000. Pulse the channel's flag for exactly this cycle, then go to IDLE.
- Non-one-hot `Motores` (e.g. 011, 111) is never a start condition.
- A level held high does not retrigger. A new start needs the bit to drop or another channel's bit to rise.
- Dose registers:
  - `load_en` with `load_sel` ≤ 2 and `load_val` ≤ `DOSE_MAX` writes the value.
  - Any other load is dropped and leaves the register unchanged.
  - A load during RUN updates the register only. The active run uses its latched `remaining`.
- Width rules:
  - Dose registers and `remaining` are 4 bits.
  - Prescaler width is $clog2(`TICKS_PER_UNIT`).

## Timing
- Reset: state IDLE, `motor_out` = 000, all flags 0, `busy` = 0, dose registers = 0, prescaler = 0, edge-detect history = 000.
- Start edge at cycle N → `motor_out` asserted from N+1. Motor-on time is exactly dose×`TICKS_PER_UNIT` cycles.
- Flag is high in the first cycle after the last motor-on cycle, simultaneous with `motor_out` returning to 000.
- Dose 0: flag at N+1, and the motor is never driven.
- The FSM leaves its state on the flag, so `Motores` switches to the next channel no earlier than flag+1. That bit's rising edge is captured in IDLE at flag+1, and its motor starts at flag+2.
- A rising edge seen while in RUN or DONE is ignored; there is no queuing.
- `reset` mid-run: motor off and flag low on the next cycle; no flag is emitted for the aborted run.
- Simultaneous `load_en` and start on the same channel: the run uses the old register value, and the new value is stored.

## Configuration
- `DOSIF_ABORT_EN` defined: in RUN, if the latched channel's bit in `Motores` goes low, then next cycle `motor_out` = 000, state is IDLE, and no flag is emitted.
- Not defined: a started run always completes and flags, regardless of `Motores`.

## Structure
- Package `dosif_pkg`:
  - state enum (IDLE/RUN/DONE);
  - channel indices CH_R/CH_Y/CH_B;
  - one-hot constants MOT_R = 3'b100, MOT_Y = 3'b010, MOT_B = 3'b001, MOT_NONE = 3'b000;
  - the digit codes 16 and 17.
- Sub-module `dosif_prescaler`: clear input, enable input, one-cycle `tick` output on wrap.

## Test plan
All scenarios use `TICKS_PER_UNIT` = 4.
- Load R=3, Y=2, B=1. Drive `Motores` 100 → 010 → 001, each advanced one cycle after its flag → motors on for 12/8/4 cycles; one flag pulse each, in order R, G, B.
- Load R with 17, then with 10 → dose R stays at its prior value 5. `Motores` = 100 → 20 motor cycles.
- Dose Y = 0, `Motores` = 010 → `flag_G` at N+1; `motor_out` stays 000.
- `reset` at cycle 6 of an R run with dose 4 → `motor_out` = 000 at cycle 7; no `flag_R` ever; dose registers cleared.
- Hold `Motores` = 100 for 30 cycles with dose R = 2 → exactly one 8-cycle run and one flag. `Motores` = 110 → no start.
- With `DOSIF_ABORT_EN`, dose B = 5, drop `Motores` to 000 after 3 motor cycles → motor off next cycle, no `flag_B`. Without the macro → 20 cycles, then `flag_B`.

Source files
------------

// File: rtl/dosif_pkg.sv
// dosif_pkg: shared types and constants for the paint dose metering stage.
// Channel indices, one-hot motor codes, FSM state encoding and the keypad
// display codes that must never be accepted as a dose.
package dosif_pkg;

  // FSM state encoding (IDLE / RUN / DONE)
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dosif_state_e;

  // Channel indices, matching the load_sel encoding
  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_Y = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;

  // One-hot motor codes, same bit order as Motores / motor_out
  localparam logic [2:0] MOT_R    = 3'b100;
  localparam logic [2:0] MOT_Y    = 3'b010;
  localparam logic [2:0] MOT_B    = 3'b001;
  localparam logic [2:0] MOT_NONE = 3'b000;

  // Keypad display codes that travel on the digit path but are not digits
  localparam logic [4:0] DIG_BLANK = 5'd16;
  localparam logic [4:0] DIG_DASH  = 5'd17;

  // Channel index to one-hot motor code
  function automatic logic [2:0] ch_to_mot(input logic [1:0] ch);
    case (ch)
      CH_R:    return MOT_R;
      CH_Y:    return MOT_Y;
      CH_B:    return MOT_B;
      default: return MOT_NONE;
    endcase
  endfunction

  // One-hot motor code to channel index (non-one-hot maps to CH_R; callers
  // only use this after checking the code is legal)
  function automatic logic [1:0] mot_to_ch(input logic [2:0] mot);
    case (mot)
      MOT_Y:   return CH_Y;
      MOT_B:   return CH_B;
      default: return CH_R;
    endcase
  endfunction

endpackage

// File: rtl/dosificador_if.sv
// dosificador_if: request/load/response bundle between the paint-loading FSM
// (master) and the dose metering stage (slave).
interface dosificador_if;
  logic [2:0] Motores;
  logic       load_en;
  logic [1:0] load_sel;
  logic [4:0] load_val;
  logic [2:0] motor_out;
  logic       flag_R;
  logic       flag_G;
  logic       flag_B;
  logic       busy;

  modport master (
    output Motores, load_en, load_sel, load_val,
    input  motor_out, flag_R, flag_G, flag_B, busy
  );

  modport slave (
    input  Motores, load_en, load_sel, load_val,
    output motor_out, flag_R, flag_G, flag_B, busy
  );
endinterface

// File: rtl/dosif_prescaler.sv
// dosif_prescaler: counts 0..TICKS-1 while enabled and emits a one-cycle tick
// in the cycle the count wraps. Clear has priority over enable.
module dosif_prescaler #(
  parameter int TICKS = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);
  localparam int W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [W-1:0] LAST = W'(TICKS - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick_o = en_i && !clr_i && (cnt_q == LAST);

  // Next count: clear, wrap at LAST, or advance
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/dosificador.sv
// dosificador: meters paint by running the requested pump for dose x
// TICKS_PER_UNIT cycles, then pulses that colour's done flag.
// Optional build macro DOSIF_ABORT_EN: dropping the active request bit during
// a run stops the motor and returns to IDLE without a flag.
module dosificador
  import dosif_pkg::*;
#(
  parameter int TICKS_PER_UNIT = 5_000_000,
  parameter int DOSE_MAX       = 9
) (
  input  logic          clk,
  input  logic          reset,
  dosificador_if.slave  bus
);
  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_RUN  = 2'(RUN);
  localparam logic [1:0] S_DONE = 2'(DONE);

  logic [1:0] state_q, state_d;
  logic [1:0] ch_q, ch_d;
  logic [3:0] rem_q, rem_d;
  logic [2:0] mot_prev_q;
  logic [3:0] dose_q [3];

  logic       mot_legal;
  logic       start;
  logic [1:0] start_ch;
  logic [3:0] start_dose;
  logic       load_ok;
  logic       tick;

  // A start needs a legal one-hot request whose bit was low last cycle
  assign mot_legal = (bus.Motores == MOT_R) || (bus.Motores == MOT_Y) ||
                     (bus.Motores == MOT_B);
  assign start     = (state_q == S_IDLE) && mot_legal &&
                     ((bus.Motores & mot_prev_q) == MOT_NONE);
  assign start_ch  = mot_to_ch(bus.Motores);

  // Display codes are listed explicitly so the intent survives a larger DOSE_MAX
  assign load_ok = bus.load_en && (bus.load_sel <= CH_B) &&
                   (int'(bus.load_val) <= DOSE_MAX) &&
                   (bus.load_val != DIG_BLANK) && (bus.load_val != DIG_DASH);

  // Dose registers: one per colour, written only by accepted loads
  for (genvar gi = 0; gi < 3; gi++) begin : g_dose
    always_ff @(posedge clk) begin
      if (reset) begin
        dose_q[gi] <= '0;
      end else if (load_ok && (bus.load_sel == 2'(gi))) begin
        dose_q[gi] <= bus.load_val[3:0];
      end
    end
  end

  // Dose of the requesting channel, read before any same-cycle load lands
  always_comb begin
    case (start_ch)
      CH_Y:    start_dose = dose_q[1];
      CH_B:    start_dose = dose_q[2];
      default: start_dose = dose_q[0];
    endcase
  end

  // Prescaler runs only in RUN and sits at zero otherwise, so every run
  // starts with a full unit
  dosif_prescaler #(.TICKS(TICKS_PER_UNIT)) u_presc (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (state_q != S_RUN),
    .en_i   (state_q == S_RUN),
    .tick_o (tick)
  );

  // FSM next-state: latch channel/dose on start, count units down in RUN
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ch_d    = start_ch;
          rem_d   = start_dose;
          state_d = (start_dose == 4'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (tick) begin
          rem_d = rem_q - 4'd1;
          if (rem_q == 4'd1) state_d = S_DONE;
        end
`ifdef DOSIF_ABORT_EN
        if ((bus.Motores & ch_to_mot(ch_q)) == MOT_NONE) begin
          rem_d   = '0;
          state_d = S_IDLE;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, channel, remaining units and request history
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ch_q       <= CH_R;
      rem_q      <= '0;
      mot_prev_q <= MOT_NONE;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      rem_q      <= rem_d;
      mot_prev_q <= bus.Motores;
    end
  end

  assign bus.motor_out = (state_q == S_RUN) ? ch_to_mot(ch_q) : MOT_NONE;
  assign bus.flag_R    = (state_q == S_DONE) && (ch_q == CH_R);
  assign bus.flag_G    = (state_q == S_DONE) && (ch_q == CH_Y);
  assign bus.flag_B    = (state_q == S_DONE) && (ch_q == CH_B);
  assign bus.busy      = (state_q == S_RUN) || (state_q == S_DONE);
endmodule

// File: tb/tb_dosificador.sv
// tb_dosificador: directed bench for dosificador with TICKS_PER_UNIT = 4.
// Build with DOSIF_ABORT_EN to match an RTL built with the abort feature.
`timescale 1ns/1ps
module tb_dosificador;
  import dosif_pkg::*;

  localparam int TPU = 4;

  logic clk = 1'b0;
  logic reset;

  dosificador_if bus ();

  dosificador #(.TICKS_PER_UNIT(TPU), .DOSE_MAX(9)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Per-channel activity recorded once per cycle: index 0 = R, 1 = Y, 2 = B
  int mot_cyc  [3];
  int flag_cnt [3];
  int flag_q   [$];
  int m0 [3];
  int f0 [3];

  // Activity monitor, sampled mid-cycle
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (bus.motor_out[2-k]) mot_cyc[k]++;
    end
    if (bus.flag_R) begin flag_cnt[0]++; flag_q.push_back(0); end
    if (bus.flag_G) begin flag_cnt[1]++; flag_q.push_back(1); end
    if (bus.flag_B) begin flag_cnt[2]++; flag_q.push_back(2); end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s: got=%0d", tag, got);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [1:0] sel, input logic [4:0] val);
    bus.load_en  = 1'b1;
    bus.load_sel = sel;
    bus.load_val = val;
    step();
    bus.load_en  = 1'b0;
  endtask

  task automatic snap();
    m0 = mot_cyc;
    f0 = flag_cnt;
  endtask

  function automatic logic flag_of(input int k);
    case (k)
      0:       return bus.flag_R;
      1:       return bus.flag_G;
      default: return bus.flag_B;
    endcase
  endfunction

  // Encodes the flag order since index qb as decimal digits (R=1, G=2, B=3)
  function automatic int seq_since(input int qb);
    int code = 0;
    for (int i = qb; i < flag_q.size(); i++) code = code * 10 + flag_q[i] + 1;
    return code;
  endfunction

  // Steps until channel k flags or the budget runs out; returns on the flag cycle
  task automatic wait_flag(input string tag, input int k, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      seen = flag_of(k);
    end
    check_eq({tag, "_flag_seen"}, int'(seen), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int qb;
    reset        = 1'b1;
    bus.Motores  = MOT_NONE;
    bus.load_en  = 1'b0;
    bus.load_sel = 2'd0;
    bus.load_val = 5'd0;
    step(3);
    check_eq("rst_motor_out", int'(bus.motor_out), 0);
    check_eq("rst_busy", int'(bus.busy), 0);
    check_eq("rst_flags", int'({bus.flag_R, bus.flag_G, bus.flag_B}), 0);
    reset = 1'b0;
    step();

    // R=3, Y=2, B=1 chained like the loading FSM does
    load(CH_R, 5'd3);
    load(CH_Y, 5'd2);
    load(CH_B, 5'd1);
    snap();
    qb = flag_q.size();
    bus.Motores = MOT_R;
    step();
    check_eq("R_start", int'(bus.motor_out), int'(MOT_R));
    check_eq("R_busy", int'(bus.busy), 1);
    wait_flag("R3", 0, 40);
    check_eq("R3_flag_motor_off", int'(bus.motor_out), 0);
    step();
    bus.Motores = MOT_Y;
    step();
    check_eq("Y_start", int'(bus.motor_out), int'(MOT_Y));
    wait_flag("Y2", 1, 40);
    step();
    bus.Motores = MOT_B;
    step();
    check_eq("B_start", int'(bus.motor_out), int'(MOT_B));
    wait_flag("B1", 2, 40);
    step(2);
    check_eq("R3_motor_cycles", mot_cyc[0] - m0[0], 12);
    check_eq("Y2_motor_cycles", mot_cyc[1] - m0[1], 8);
    check_eq("B1_motor_cycles", mot_cyc[2] - m0[2], 4);
    check_eq("chain_flag_order", seq_since(qb), 123);

    // Rejected loads leave R at 5
    bus.Motores = MOT_NONE;
    load(CH_R, 5'd5);
    load(CH_R, DIG_DASH);
    load(CH_R, 5'd10);
    load(CH_R, DIG_BLANK);
    load(2'd3, 5'd2);
    snap();
    bus.Motores = MOT_R;
    wait_flag("R5", 0, 60);
    step();
    check_eq("R5_motor_cycles", mot_cyc[0] - m0[0], 20);
    check_eq("R5_flag_count", flag_cnt[0] - f0[0], 1);

    // Dose zero: flag next cycle, motor never driven
    bus.Motores = MOT_NONE;
    load(CH_Y, 5'd0);
    snap();
    bus.Motores = MOT_Y;
    step();
    check_eq("Y0_flag_at_N1", int'(bus.flag_G), 1);
    check_eq("Y0_motor_off", int'(bus.motor_out), 0);
    step(3);
    check_eq("Y0_motor_cycles", mot_cyc[1] - m0[1], 0);

    // Load and start on the same channel in the same cycle
    bus.Motores = MOT_NONE;
    load(CH_Y, 5'd2);
    snap();
    bus.load_en  = 1'b1;
    bus.load_sel = CH_Y;
    bus.load_val = 5'd0;
    bus.Motores  = MOT_Y;
    step();
    bus.load_en  = 1'b0;
    wait_flag("Ysim", 1, 40);
    step();
    check_eq("Ysim_old_dose_cycles", mot_cyc[1] - m0[1], 8);
    bus.Motores = MOT_NONE;
    step();
    bus.Motores = MOT_Y;
    step();
    check_eq("Ysim_new_dose_zero", int'(bus.flag_G), 1);

    // Reset in the sixth motor cycle of an R run with dose 4
    bus.Motores = MOT_NONE;
    load(CH_R, 5'd4);
    step();
    snap();
    bus.Motores = MOT_R;
    step(6);
    reset       = 1'b1;
    bus.Motores = MOT_NONE;
    step();
    check_eq("rstrun_motor_off", int'(bus.motor_out), 0);
    check_eq("rstrun_flag_R", int'(bus.flag_R), 0);
    reset = 1'b0;
    step(20);
    check_eq("rstrun_no_flag", flag_cnt[0] - f0[0], 0);
    check_eq("rstrun_motor_cycles", mot_cyc[0] - m0[0], 6);
    bus.Motores = MOT_R;
    step();
    check_eq("rstrun_dose_cleared", int'(bus.flag_R), 1);

    // Held request runs once; two bits set never start
    bus.Motores = MOT_NONE;
    load(CH_R, 5'd2);
    step();
    snap();
    bus.Motores = MOT_R;
    step(30);
    check_eq("hold_motor_cycles", mot_cyc[0] - m0[0], 8);
    check_eq("hold_flag_count", flag_cnt[0] - f0[0], 1);
    bus.Motores = MOT_NONE;
    step();
    snap();
    bus.Motores = 3'b110;
    step(10);
    check_eq("twohot_motor_cycles",
             (mot_cyc[0] - m0[0]) + (mot_cyc[1] - m0[1]) + (mot_cyc[2] - m0[2]), 0);
    check_eq("twohot_busy", int'(bus.busy), 0);

    // Request dropped after three motor cycles of a B run with dose 5
    bus.Motores = MOT_NONE;
    load(CH_B, 5'd5);
    step();
    snap();
    bus.Motores = MOT_B;
    step(3);
    bus.Motores = MOT_NONE;
    step();
`ifdef DOSIF_ABORT_EN
    check_eq("drop_motor_next", int'(bus.motor_out), 0);
`else
    check_eq("drop_motor_next", int'(bus.motor_out), int'(MOT_B));
`endif
    step(30);
`ifdef DOSIF_ABORT_EN
    check_eq("drop_motor_cycles", mot_cyc[2] - m0[2], 3);
    check_eq("drop_flag_B", flag_cnt[2] - f0[2], 0);
`else
    check_eq("drop_motor_cycles", mot_cyc[2] - m0[2], 20);
    check_eq("drop_flag_B", flag_cnt[2] - f0[2], 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
